// File: rtl/fdiv_prog.sv
// fdiv_prog -- runtime-programmable clock divider / tick generator.
//
// Divides the system clock by a divisor N that can be changed while running.
// N is reset to DEFAULT_DIV. While counting, a new divisor is held in a
// pending register and takes effect at the next period boundary, so the
// period in progress always finishes with the old N. While idle (en=0) the
// new divisor takes effect at once.
//
// Ports:
//   clk      in   system clock, rising edge
//   nrst     in   synchronous active-high reset (1 = reset)
//   en       in   count enable
//   mode     in   0 = square wave on div_clk, 1 = one-cycle pulse on div_clk
//   div_val  in   new divisor, sampled only when load=1 (0 is stored as 1)
//   load     in   one-cycle divisor change request
//   pending  out  a loaded divisor is waiting for the next period boundary
//   div_clk  out  divided output (fabric signal, never a clock net)
//   tick     out  one-cycle pulse once per N enabled cycles
//   cnt      out  current counter value, 0..N-1
//
// All outputs are registered.

module fdiv_prog #(
   parameter int unsigned CNT_W       = 26,
   parameter int unsigned DEFAULT_DIV = 50000000
) (
   input  logic             clk,
   input  logic             nrst,
   input  logic             en,
   input  logic             mode,
   input  logic [CNT_W-1:0] div_val,
   input  logic             load,
   output logic             pending,
   output logic             div_clk,
   output logic             tick,
   output logic [CNT_W-1:0] cnt
);

   // A divisor of 0 is meaningless; store it as 1 so N-1 never underflows.
   function automatic logic [CNT_W-1:0] f_clamp(input logic [CNT_W-1:0] v);
      return (v == '0) ? CNT_W'(1) : v;
   endfunction

   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] r_div;        // active divisor N
   logic [CNT_W-1:0] r_pend_val;   // divisor waiting for the next wrap
   logic             r_pending;
   logic             r_div_clk;
   logic             r_tick;

   logic             w_wrap;
   logic [CNT_W-1:0] w_load_val;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [CNT_W-1:0] w_div_nxt;
   logic [CNT_W-1:0] w_pend_val_nxt;
   logic             w_pending_nxt;
   logic             w_div_clk_nxt;
   logic             w_tick_nxt;

   assign w_wrap     = en && (r_cnt == (r_div - CNT_W'(1)));
   assign w_load_val = f_clamp(div_val);

   always_comb begin
      w_cnt_nxt      = r_cnt;
      w_div_nxt      = r_div;
      w_pend_val_nxt = r_pend_val;
      w_pending_nxt  = r_pending;
      w_tick_nxt     = 1'b0;
      // Square mode holds between wraps; pulse mode drops back to 0.
      w_div_clk_nxt  = mode ? 1'b0 : r_div_clk;

      if (!en) begin
         // Idle reload applies immediately and restarts the count, which keeps
         // cnt <= N-1 even when the new divisor is smaller.
         if (load) begin
            w_div_nxt     = w_load_val;
            w_cnt_nxt     = '0;
            w_pending_nxt = 1'b0;
         end
      end else if (w_wrap) begin
         w_cnt_nxt     = '0;
         w_tick_nxt    = 1'b1;
         w_div_clk_nxt = mode ? 1'b1 : ~r_div_clk;
         // A load on the wrap edge wins over (and discards) an older pending value.
         if (load) begin
            w_div_nxt = w_load_val;
         end else if (r_pending) begin
            w_div_nxt = r_pend_val;
         end
         w_pending_nxt = 1'b0;
      end else begin
         w_cnt_nxt = r_cnt + CNT_W'(1);
         if (load) begin
            w_pend_val_nxt = w_load_val;
            w_pending_nxt  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (nrst) begin
         r_cnt      <= '0;
         r_div      <= CNT_W'(DEFAULT_DIV);
         r_pend_val <= '0;
         r_pending  <= 1'b0;
         r_div_clk  <= 1'b0;
         r_tick     <= 1'b0;
      end else begin
         r_cnt      <= w_cnt_nxt;
         r_div      <= w_div_nxt;
         r_pend_val <= w_pend_val_nxt;
         r_pending  <= w_pending_nxt;
         r_div_clk  <= w_div_clk_nxt;
         r_tick     <= w_tick_nxt;
      end
   end

   assign cnt     = r_cnt;
   assign pending = r_pending;
   assign div_clk = r_div_clk;
   assign tick    = r_tick;

endmodule

// File: tb/tb_fdiv_prog.sv
// tb_fdiv_prog -- directed self-checking bench for fdiv_prog
// (CNT_W=8, DEFAULT_DIV=4, 20 ns clock).

module tb_fdiv_prog;

   logic       clk;
   logic       nrst;
   logic       en;
   logic       mode;
   logic [7:0] div_val;
   logic       load;
   logic       pending;
   logic       div_clk;
   logic       tick;
   logic [7:0] cnt;

   int unsigned n_checks;
   int unsigned n_fail;
   int unsigned n_pulse;

   // Hand-computed square-mode sequence after reset release, N=4.
   int t1_cnt [8] = '{1, 2, 3, 0, 1, 2, 3, 0};
   int t1_tick[8] = '{0, 0, 0, 1, 0, 0, 0, 1};
   int t1_dc  [8] = '{0, 0, 0, 1, 1, 1, 1, 0};

   fdiv_prog #(
      .CNT_W      (8),
      .DEFAULT_DIV(4)
   ) dut (
      .clk    (clk),
      .nrst   (nrst),
      .en     (en),
      .mode   (mode),
      .div_val(div_val),
      .load   (load),
      .pending(pending),
      .div_clk(div_clk),
      .tick   (tick),
      .cnt    (cnt)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Advance one rising edge, then settle so outputs are sampled away from it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      nrst     = 1'b1;
      en       = 1'b0;
      mode     = 1'b0;
      load     = 1'b0;
      div_val  = '0;

      // 1. Reset, then square mode with N=4
      for (int i = 0; i < 3; i++) begin
         step();
         chk("rst_cnt",  int'(cnt),     0);
         chk("rst_tick", int'(tick),    0);
         chk("rst_dc",   int'(div_clk), 0);
         chk("rst_pend", int'(pending), 0);
      end
      nrst = 1'b0;
      en   = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step();
         chk("sq_cnt",  int'(cnt),     t1_cnt[i]);
         chk("sq_tick", int'(tick),    t1_tick[i]);
         chk("sq_dc",   int'(div_clk), t1_dc[i]);
      end

      // 2. Pulse mode, 20 cycles from cnt=0
      mode    = 1'b1;
      n_pulse = 0;
      for (int i = 1; i <= 20; i++) begin
         step();
         chk("pl_tick", int'(tick),    (i % 4 == 0) ? 1 : 0);
         chk("pl_dc",   int'(div_clk), (i % 4 == 0) ? 1 : 0);
         if (tick) n_pulse++;
      end
      chk("pl_count", int'(n_pulse), 5);

      // 3. Deferred reload of 6 requested at cnt=1
      mode = 1'b0;
      step();
      chk("dr_cnt1", int'(cnt), 1);
      load    = 1'b1;
      div_val = 8'd6;
      step();
      load = 1'b0;
      chk("dr_cnt2",  int'(cnt),     2);
      chk("dr_pend2", int'(pending), 1);
      step();
      chk("dr_cnt3",  int'(cnt),     3);
      chk("dr_pend3", int'(pending), 1);
      step();
      chk("dr_wcnt",  int'(cnt),     0);
      chk("dr_wtick", int'(tick),    1);
      chk("dr_wpend", int'(pending), 0);
      chk("dr_wdc",   int'(div_clk), 0);
      for (int i = 1; i <= 6; i++) begin
         step();
         chk("dr_n6_cnt",  int'(cnt),  i % 6);
         chk("dr_n6_tick", int'(tick), (i == 6) ? 1 : 0);
      end

      // 4. Load of 0 on a wrap edge: clamps to N=1, no pending
      repeat (5) step();
      chk("cl_pre_cnt", int'(cnt), 5);
      load    = 1'b1;
      div_val = 8'd0;
      step();
      load = 1'b0;
      chk("cl_cnt",  int'(cnt),     0);
      chk("cl_tick", int'(tick),    1);
      chk("cl_pend", int'(pending), 0);
      chk("cl_dc",   int'(div_clk), 0);
      for (int i = 1; i <= 6; i++) begin
         step();
         chk("n1_tick", int'(tick),    1);
         chk("n1_cnt",  int'(cnt),     0);
         chk("n1_pend", int'(pending), 0);
         chk("n1_dc",   int'(div_clk), i % 2);
      end

      // 5. Idle reload back to N=4, then enable gating at cnt=2
      en      = 1'b0;
      load    = 1'b1;
      div_val = 8'd4;
      step();
      load = 1'b0;
      chk("il_cnt",  int'(cnt),     0);
      chk("il_tick", int'(tick),    0);
      chk("il_pend", int'(pending), 0);
      chk("il_dc",   int'(div_clk), 0);
      en = 1'b1;
      step();
      chk("eg_cnt1", int'(cnt), 1);
      step();
      chk("eg_cnt2", int'(cnt), 2);
      en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("eg_hold_cnt",  int'(cnt),     2);
         chk("eg_hold_tick", int'(tick),    0);
         chk("eg_hold_dc",   int'(div_clk), 0);
      end
      en = 1'b1;
      step();
      chk("eg_cnt3",  int'(cnt),  3);
      chk("eg_tick3", int'(tick), 0);
      step();
      chk("eg_wcnt",  int'(cnt),     0);
      chk("eg_wtick", int'(tick),    1);
      chk("eg_wdc",   int'(div_clk), 1);

      // 6. Reset while a reload of 9 is pending (load also asserted during reset)
      step();
      chk("mr_cnt1", int'(cnt), 1);
      load    = 1'b1;
      div_val = 8'd9;
      step();
      load = 1'b0;
      chk("mr_cnt2",  int'(cnt),     2);
      chk("mr_pend2", int'(pending), 1);
      step();
      chk("mr_cnt3",  int'(cnt),     3);
      chk("mr_pend3", int'(pending), 1);
      nrst = 1'b1;
      load = 1'b1;
      step();
      nrst = 1'b0;
      load = 1'b0;
      chk("mr_rst_cnt",  int'(cnt),     0);
      chk("mr_rst_pend", int'(pending), 0);
      chk("mr_rst_dc",   int'(div_clk), 0);
      chk("mr_rst_tick", int'(tick),    0);
      for (int i = 1; i <= 4; i++) begin
         step();
         chk("mr_n4_cnt",  int'(cnt),  i % 4);
         chk("mr_n4_tick", int'(tick), (i == 4) ? 1 : 0);
      end
      chk("mr_n4_dc", int'(div_clk), 1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fdiv_prog.md
Name: fdiv_prog

Overview:
- Parametrised, runtime-programmable successor to the fixed clock divider.
- Derives a slow timing signal from the 50 MHz system clock. Outputs are either a square wave (`div_clk`) or a one-cycle enable pulse (`tick`).
- Adds runtime divisor reload with glitch-free application at period boundaries, a pulse/square output mode, and a count-enable.
- Feeds the FSM timers (vending timeouts, display refresh). Everything runs on the `clk` domain; `div_clk` is a fabric signal and never drives a clock net.

Parameters:
- CNT_W, 26, width of the counter and divisor; covers divisors up to 2^CNT_W-1.
- DEFAULT_DIV, 50000000, divisor N loaded at reset (1 Hz tick at 50 MHz); must be ≥1 and < 2^CNT_W.

Ports:
- clk  in  1  system clock, rising edge.
- nrst  in  1  synchronous, active-high reset; 1 = reset, sampled on the `clk` rising edge.
- en  in  1  count enable.
- mode  in  1  0 = square output on `div_clk`; 1 = pulse output on `div_clk`.
- div_val  in  CNT_W  new divisor value; sampled only when `load`=1.
- load  in  1  one-cycle request to change the divisor.
- pending  out  1  a loaded divisor is waiting for the next period boundary.
- div_clk  out  1  divided output.
- tick  out  1  one-cycle pulse, once per N enabled cycles.
- cnt  out  CNT_W  current counter value, 0..N-1.

Behaviour:
- Reset (`nrst`=1 at an edge) overrides all other inputs, including `load`:
  - `cnt`=0, `div_clk`=0, `tick`=0, `pending`=0;
  - active divisor N=DEFAULT_DIV; pending register cleared.
- Divisor clamp: a loaded value of 0 is stored as 1. All other values are stored unchanged. N is always ≥1.
- Wrap condition W = (`en`=1 and `cnt`==N-1).
- Each edge when not in reset:
  - W=1: `cnt`←0, `tick`←1; `div_clk` toggles if `mode`=0, `div_clk`←1 if `mode`=1.
  - `en`=1 and W=0: `cnt`←`cnt`+1, `tick`←0; `div_clk` holds if `mode`=0, `div_clk`←0 if `mode`=1.
  - `en`=0: `cnt` holds, `tick`←0; `div_clk` holds if `mode`=0, `div_clk`←0 if `mode`=1.
- Resulting timing:
  - `tick` and pulse-mode `div_clk` are high for exactly one cycle, registered, on the cycle after the wrap edge.
  - Square mode has a period of 2N enabled cycles at 50 % duty.
  - N=1 gives `tick` continuously high and square-mode `div_clk` at clk/2.
- Divisor reload:
  - `load`=1 at an edge with W=0 and `en`=1: stores clamp(`div_val`) into the pending register and sets `pending`=1.
  - At the next W edge: N←pending value, `pending`←0. The current period always completes with the old N.
  - `load`=1 on a W edge: N←clamp(`div_val`) directly at that wrap. `pending` stays 0, and any older pending value is discarded.
  - `load`=1 while `pending`=1: the new value overwrites the pending value; `pending` stays 1.
  - `load`=1 while `en`=0: N←clamp(`div_val`), `cnt`←0, `pending`←0 at that edge, i.e. immediate reload while idle.
  - `pending`=1 and `en` falling to 0 with no new `load`: the pending value is kept until the next W edge.
- `mode` changes take effect at the next edge. No counter restart.
- Invariant: `cnt` ≤ N-1 at all times. N changes only when `cnt`=0 is being loaded.
- `div_clk`, `tick`, `cnt` and `pending` are all registered outputs. No combinational path from inputs to outputs.

Test Plan (CNT_W=8, DEFAULT_DIV=4, 20 ns clk):
1. Reset and square mode:
   - Stimulus: `nrst`=1 for 3 cycles; then `nrst`=0, `en`=1, `mode`=0.
   - Required response: all outputs 0 during reset; `cnt` sequence 0,1,2,3,0; `tick` high 1 cycle in every 4; `div_clk` toggles on each wrap (period 8 cycles, 4 high / 4 low).
2. Pulse mode:
   - Stimulus: `mode`=1, `en`=1, N=4, run 20 cycles.
   - Required response: `div_clk`==`tick` every cycle; each is high exactly 5 times, spaced 4 cycles apart.
3. Deferred reload:
   - Stimulus: at `cnt`=1, `load`=1 with `div_val`=6.
   - Required response: `pending`=1 for the next 2 edges; current period ends after 4 counts; next period runs `cnt` 0..5 (`tick` spacing 6); `pending` returns to 0 at the wrap.
4. Clamp and same-edge load:
   - Stimulus: `load` with `div_val`=0 on a W edge.
   - Required response: `pending` never set; N=1; `tick` held high every following cycle; square `div_clk` toggles every cycle.
5. Enable gating:
   - Stimulus: `en`=0 at `cnt`=2 for 5 cycles, `mode`=0.
   - Required response: `cnt` holds 2, `tick`=0, `div_clk` holds; after `en`=1, `cnt`=3 at the next edge and `tick`=1 one edge later.
6. Reset mid-operation:
   - Stimulus: `pending`=1 (`div_val`=9 loaded) and `cnt`=3, then `nrst`=1 for 1 cycle.
   - Required response: `pending`=0, `cnt`=0, `div_clk`=0; the following period uses N=4, not 9.
